// File: rtl/gpo_ser_pkg.sv
// gpo_ser_pkg: shared state encoding for the GPO shift serializer
package gpo_ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} ser_state_t;
endpackage

// File: rtl/gpo_ser_tick.sv
// gpo_ser_tick: CLK_DIV phase counter with sync clear and terminal-count flag
module gpo_ser_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tc
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : r_cnt + 1'b1;
  assign o_tc = r_cnt == DW'(CLK_DIV - 1);
endmodule

// File: rtl/gpo_shift_serializer.sv
// gpo_shift_serializer: ships the parallel GPO word MSB-first to a 595-style chain
module gpo_shift_serializer
  import gpo_ser_pkg::*;
#(
  parameter int W       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  input  logic         refresh,
  output logic         sclk,
  output logic         sdata,
  output logic         latch,
  output logic         busy
);
  localparam int BW = W > 1 ? $clog2(W) : 1;
  ser_state_t    r_state;
  logic [W-1:0]  r_shift, r_sent, w_next;
  logic [BW-1:0] r_bit;
  logic          r_pend, w_tc, w_start;
  assign w_start = (din != r_sent) | r_pend | refresh;
  assign w_next  = r_shift << 1;
  // IDLE holds the divider at zero so every phase starts from a fresh count
  gpo_ser_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  ((r_state == IDLE) | w_tc),
    .o_tc   (w_tc)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_sent  <= '0;
      r_pend  <= 1'b0;
      r_bit   <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (r_state != IDLE && refresh) r_pend <= 1'b1;
      case (r_state)
        IDLE: if (w_start) begin
          r_shift <= din;
          r_sent  <= din;
          r_pend  <= 1'b0;
          r_bit   <= '0;
          busy    <= 1'b1;
          sdata   <= din[W-1];
          r_state <= SHIFT_LO;
        end
        SHIFT_LO: if (w_tc) begin
          sclk    <= 1'b1;
          r_state <= SHIFT_HI;
        end
        SHIFT_HI: if (w_tc) begin
          r_shift <= w_next;
          sclk    <= 1'b0;
          if (r_bit == BW'(W - 1)) begin
            sdata   <= 1'b0;
            latch   <= 1'b1;
            r_state <= LATCH;
          end else begin
            r_bit   <= r_bit + 1'b1;
            sdata   <= w_next[W-1];
            r_state <= SHIFT_LO;
          end
        end
        LATCH: if (w_tc) begin
          latch   <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gpo_shift_serializer.sv
// tb_gpo_shift_serializer: directed vectors against a 595 chain model
module tb_gpo_shift_serializer;
  logic       clk = 0, reset_n = 0, refresh = 0, refresh1 = 0;
  logic [7:0] din = 0;
  logic [3:0] din1 = 0;
  logic       sclk, sdata, latch, busy, sclk1, sdata1, latch1, busy1;
  logic [7:0] m_sr = 0, m_q = 0;
  logic [3:0] m1_sr = 0, m1_q = 0;
  int         n_rise = 0, n_lat = 0, n_vec = 0, n_err = 0;
  int         bc, lc, g, r0, l0, bs, ss;
  always #5 clk = ~clk;
  gpo_shift_serializer #(.W(8), .CLK_DIV(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .din(din), .refresh(refresh),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy)
  );
  gpo_shift_serializer #(.W(4), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .din(din1), .refresh(refresh1),
    .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1)
  );
  always @(posedge sclk) begin
    m_sr   <= {m_sr[6:0], sdata};
    n_rise <= n_rise + 1;
  end
  always @(posedge latch) begin
    m_q   <= m_sr;
    n_lat <= n_lat + 1;
  end
  always @(posedge sclk1) m1_sr <= {m1_sr[2:0], sdata1};
  always @(posedge latch1) m1_q <= m1_sr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_busy(output int t);
    t = 0;
    while (!busy && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!busy) chk("start_timeout", busy, 1);
  endtask
  task automatic run(input int chg_at, input logic [7:0] chg_val, input int rf_a, input int rf_b,
                     output int b, output int l);
    int t;
    wait_busy(t);
    b = 0;
    l = 0;
    while (busy && b < 500) begin
      b++;
      l += int'(latch);
      if (b == chg_at) din = chg_val;
      refresh = (b == rf_a) || (b == rf_b);
      @(negedge clk);
    end
    refresh = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_latch", latch, 0);
    reset_n = 1;
    bs = 0;
    ss = 0;
    repeat (100) begin
      @(negedge clk);
      bs |= int'(busy);
      ss |= int'(sclk | sdata | latch);
    end
    chk("idle_busy", bs, 0);
    chk("idle_pins", ss, 0);
    // single transfer of A5
    r0 = n_rise;
    din = 8'hA5;
    run(0, 0, 0, 0, bc, lc);
    chk("a5_busy_cyc", bc, 68);
    chk("a5_rises", n_rise - r0, 8);
    chk("a5_latch_cyc", lc, 4);
    chk("a5_q", m_q, 8'hA5);
    // din changes mid-transfer
    din = 8'h01;
    run(10, 8'hFF, 0, 0, bc, lc);
    chk("x01_busy_cyc", bc, 68);
    chk("x01_q", m_q, 8'h01);
    g = 0;
    while (!busy && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk("gap_cyc", g, 1);
    run(0, 0, 0, 0, bc, lc);
    chk("xff_busy_cyc", bc, 68);
    chk("xff_q", m_q, 8'hFF);
    // refresh while idle and twice while busy
    din = 8'h3C;
    run(0, 0, 0, 0, bc, lc);
    chk("x3c_q", m_q, 8'h3C);
    repeat (5) @(negedge clk);
    l0 = n_lat;
    m_sr = 0;
    refresh = 1;
    @(negedge clk);
    refresh = 0;
    chk("rf_start", busy, 1);
    run(0, 0, 5, 20, bc, lc);
    chk("rf1_busy_cyc", bc, 68);
    chk("rf1_q", m_q, 8'h3C);
    run(0, 0, 0, 0, bc, lc);
    chk("rf2_busy_cyc", bc, 68);
    bs = 0;
    repeat (100) begin
      @(negedge clk);
      bs |= int'(busy);
    end
    chk("rf_no_third", bs, 0);
    chk("rf_xfers", n_lat - l0, 2);
    chk("rf2_q", m_q, 8'h3C);
    // reset during bit 3 of C3
    r0 = n_rise;
    din = 8'hC3;
    wait_busy(g);
    repeat (26) @(negedge clk);
    chk("abort_rises", n_rise - r0, 3);
    reset_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_sdata", sdata, 0);
    chk("abort_latch", latch, 0);
    chk("abort_keep_q", m_q, 8'h3C);
    @(negedge clk);
    reset_n = 1;
    run(0, 0, 0, 0, bc, lc);
    chk("resend_busy_cyc", bc, 68);
    chk("resend_q", m_q, 8'hC3);
    // W=4, CLK_DIV=1 instance
    chk("w4_idle", busy1, 0);
    din1 = 4'h9;
    g = 0;
    while (!busy1 && g < 50) begin
      g++;
      @(negedge clk);
    end
    bc = 0;
    while (busy1 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("w4_busy_cyc", bc, 9);
    chk("w4_q", m1_q, 4'h9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
